// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard and stall controller for the five-stage CPU.
//             Detects ID/EX load-use hazards, applies branch/jump flushes and
//             freezes the whole pipeline while a multi-cycle data-memory
//             access occupies MEM (IDLE / RUN / MEM_WAIT FSM + down-counter).
//  Ports    : clk_i, rst_i (async, active-low), start_i       - control
//             IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i,
//             IFID_UsesRt_i                                   - load-use
//             EXMEM_MemAccess_i                               - memory freeze
//             Branch_i, Jump_i                                - control flush
//             PCWrite_o, IFIDWrite_o, IFIDFlush_o,
//             IDEXBubble_o, PipeStall_o                       - pipeline ctrl
//             stall_cycles_o (only with HAZ_PERF_CNT_EN)      - perf counter
//  Options  : HAZ_PERF_CNT_EN - adds a saturating 32-bit stall-cycle counter.
//  Params   : MEM_LAT (1..15) cycles in MEM, CNT_W with 2**CNT_W > MEM_LAT.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       IDEX_MemRead_i,
    input  logic [4:0] IDEX_Rt_i,
    input  logic [4:0] IFID_Rs_i,
    input  logic [4:0] IFID_Rt_i,
    input  logic       IFID_UsesRt_i,
    input  logic       EXMEM_MemAccess_i,
    input  logic       Branch_i,
    input  logic       Jump_i,
    output logic       PCWrite_o,
    output logic       IFIDWrite_o,
    output logic       IFIDFlush_o,
    output logic       IDEXBubble_o,
    output logic       PipeStall_o
`ifdef HAZ_PERF_CNT_EN
   ,output logic [31:0] stall_cycles_o
`endif
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_RUN      = 2'd1;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd2;

    // A single-cycle access never needs the wait state.
    localparam bit         c_MULTI_CYCLE = (MEM_LAT > 1);
    // The RUN cycle that first sees the access is itself a freeze cycle, so
    // the counter covers the remaining MEM_LAT-2 frozen cycles.
    localparam int         c_LOAD_INT    = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(c_LOAD_INT);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_freeze;
    logic w_eval;
    logic w_load_use;
    logic w_ctrl_flush;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_pipe_stall;

    // Freeze: new access seen in RUN, or wait still counting down.
    assign w_freeze = ((r_state == c_ST_RUN) && EXMEM_MemAccess_i && c_MULTI_CYCLE) ||
                      ((r_state == c_ST_MEM_WAIT) && (r_cnt != '0));

    // Hazard/flush logic is live in RUN and in the MEM_WAIT release cycle.
    assign w_eval = (r_state == c_ST_RUN) ||
                    ((r_state == c_ST_MEM_WAIT) && (r_cnt == '0));

    assign w_load_use = w_eval && IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                        ((IDEX_Rt_i == IFID_Rs_i) ||
                         (IFID_UsesRt_i && (IDEX_Rt_i == IFID_Rt_i)));

    assign w_ctrl_flush = w_eval && (Branch_i || Jump_i);

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_stall  = 1'b0;
        if (r_state == c_ST_IDLE) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_pipe_stall  = 1'b1;
        end else if (w_freeze) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_pipe_stall  = 1'b1;
        end else if (w_load_use) begin
            // Branch in the same cycle is dropped here; it re-evaluates
            // once the load has left EX.
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end else if (w_ctrl_flush) begin
            w_ifid_flush  = 1'b1;
        end
    end

    assign PCWrite_o    = w_pc_write;
    assign IFIDWrite_o  = w_ifid_write;
    assign IFIDFlush_o  = w_ifid_flush;
    assign IDEXBubble_o = w_idex_bubble;
    assign PipeStall_o  = w_pipe_stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (start_i) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (!start_i) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end else if (EXMEM_MemAccess_i && c_MULTI_CYCLE) begin
                        r_state <= c_ST_MEM_WAIT;
                        r_cnt   <= c_CNT_LOAD;
                    end
                end
                c_ST_MEM_WAIT: begin
                    if (!start_i) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                    end else begin
                        // Release cycle: access in MEM is ignored.
                        r_state <= c_ST_RUN;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cycles <= 32'd0;
        end else if (((r_state == c_ST_RUN) || (r_state == c_ST_MEM_WAIT)) &&
                     !w_pc_write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl. Two instances share the
//             stimulus: MEM_LAT=3 and MEM_LAT=1. Expected output vectors
//             {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeStall} are
//             queued by the driver and compared by a monitor on the falling
//             edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       memread = 1'b0;
    logic [4:0] idex_rt = 5'd0;
    logic [4:0] ifid_rs = 5'd0;
    logic [4:0] ifid_rt = 5'd0;
    logic       uses_rt = 1'b0;
    logic       memacc = 1'b0;
    logic       branch = 1'b0;
    logic       jump = 1'b0;

    logic [4:0] out3;
    logic [4:0] out1;
    logic [31:0] pc3;
    logic [31:0] pc1;

    always #5 clk = ~clk;

    // Output encodings {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeStall}
    localparam logic [4:0] c_IDL = 5'b00011;
    localparam logic [4:0] c_RUN = 5'b11000;
    localparam logic [4:0] c_FRZ = 5'b00001;
    localparam logic [4:0] c_LU  = 5'b00010;
    localparam logic [4:0] c_FL  = 5'b11100;

    hazard_ctrl #(.MEM_LAT(3), .CNT_W(4)) u_dut3 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .IDEX_MemRead_i(memread), .IDEX_Rt_i(idex_rt),
        .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt), .IFID_UsesRt_i(uses_rt),
        .EXMEM_MemAccess_i(memacc), .Branch_i(branch), .Jump_i(jump),
        .PCWrite_o(out3[4]), .IFIDWrite_o(out3[3]), .IFIDFlush_o(out3[2]),
        .IDEXBubble_o(out3[1]), .PipeStall_o(out3[0])
`ifdef HAZ_PERF_CNT_EN
       ,.stall_cycles_o(pc3)
`endif
    );

    hazard_ctrl #(.MEM_LAT(1), .CNT_W(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .IDEX_MemRead_i(memread), .IDEX_Rt_i(idex_rt),
        .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt), .IFID_UsesRt_i(uses_rt),
        .EXMEM_MemAccess_i(memacc), .Branch_i(branch), .Jump_i(jump),
        .PCWrite_o(out1[4]), .IFIDWrite_o(out1[3]), .IFIDFlush_o(out1[2]),
        .IDEXBubble_o(out1[1]), .PipeStall_o(out1[0])
`ifdef HAZ_PERF_CNT_EN
       ,.stall_cycles_o(pc1)
`endif
    );

`ifndef HAZ_PERF_CNT_EN
    assign pc3 = 32'd0;
    assign pc1 = 32'd0;
`endif

    typedef struct {
        string       name;
        logic [4:0]  e3;
        logic [4:0]  e1;
        bit          chk_pc;
        logic [31:0] epc3;
        logic [31:0] epc1;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   errors = 0;
    int   checks = 0;

    // Monitor: one expected entry per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            checks++;
            if (out3 !== m_e.e3) begin
                errors++;
                $display("FAIL %s lat3: got %b want %b", m_e.name, out3, m_e.e3);
            end
            checks++;
            if (out1 !== m_e.e1) begin
                errors++;
                $display("FAIL %s lat1: got %b want %b", m_e.name, out1, m_e.e1);
            end
`ifdef HAZ_PERF_CNT_EN
            if (m_e.chk_pc) begin
                checks++;
                if (pc3 !== m_e.epc3) begin
                    errors++;
                    $display("FAIL %s perf lat3: got %0d want %0d", m_e.name, pc3, m_e.epc3);
                end
                checks++;
                if (pc1 !== m_e.epc1) begin
                    errors++;
                    $display("FAIL %s perf lat1: got %0d want %0d", m_e.name, pc1, m_e.epc1);
                end
            end
`endif
        end
    end

    task automatic step(input string nm, input logic rs_n, input logic st,
                        input logic mr, input logic [4:0] xrt,
                        input logic [4:0] srs, input logic [4:0] srt,
                        input logic ur, input logic ma, input logic br,
                        input logic jp, input logic [4:0] e3, input logic [4:0] e1,
                        input bit cpc = 1'b0, input logic [31:0] p3 = 32'd0,
                        input logic [31:0] p1 = 32'd0);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rs_n; start = st; memread = mr; idex_rt = xrt;
        ifid_rs = srs; ifid_rt = srt; uses_rt = ur; memacc = ma;
        branch = br; jump = jp;
        e.name = nm; e.e3 = e3; e.e1 = e1;
        e.chk_pc = cpc; e.epc3 = p3; e.epc1 = p1;
        q.push_back(e);
    endtask

    initial begin
        //    name           rst st mr xrt rs rt ur ma br jp  lat3   lat1
        step("reset",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_IDL, c_IDL);
        step("idle1",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_IDL, c_IDL);
        step("idle_start",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, c_IDL, c_IDL);
        step("run",          1, 1, 0, 0, 0, 0, 0, 0, 0, 0, c_RUN, c_RUN);
        step("lu_rs5",       1, 1, 1, 5, 5, 0, 0, 0, 0, 0, c_LU,  c_LU);
        step("lu_rt0",       1, 1, 1, 0, 0, 0, 1, 0, 0, 0, c_RUN, c_RUN);
        step("lu_rt7",       1, 1, 1, 7, 1, 7, 1, 0, 0, 0, c_LU,  c_LU);
        step("lu_rt_unused", 1, 1, 1, 7, 1, 7, 0, 0, 0, 0, c_RUN, c_RUN);
        step("lu_and_br",    1, 1, 1, 9, 9, 0, 0, 0, 1, 0, c_LU,  c_LU);
        step("br_alone",     1, 1, 0, 9, 9, 0, 0, 0, 1, 0, c_FL,  c_FL);
        step("jump",         1, 1, 0, 0, 0, 0, 0, 0, 0, 1, c_FL,  c_FL);
        step("mem_n",        1, 1, 0, 0, 0, 0, 0, 1, 0, 0, c_FRZ, c_RUN);
        step("mem_n1",       1, 1, 1, 3, 3, 0, 0, 1, 1, 0, c_FRZ, c_LU);
        step("mem_release",  1, 1, 0, 0, 0, 0, 0, 1, 1, 0, c_FL,  c_FL);
        step("mem2_n",       1, 1, 0, 0, 0, 0, 0, 1, 0, 0, c_FRZ, c_RUN);
        step("mem2_n1",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0, c_FRZ, c_RUN);
        step("mem2_rel_lu",  1, 1, 1, 4, 0, 4, 1, 0, 0, 0, c_LU,  c_LU);
        step("mem3_n",       1, 1, 0, 0, 0, 0, 0, 1, 0, 0, c_FRZ, c_RUN, 1'b1, 32'd8, 32'd5);
        step("rst_midwait",  0, 1, 0, 0, 0, 0, 0, 1, 0, 0, c_IDL, c_IDL, 1'b1, 32'd0, 32'd0);
        step("restart",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0, c_IDL, c_IDL);
        step("mem4_n",       1, 1, 0, 0, 0, 0, 0, 1, 0, 0, c_FRZ, c_RUN);
        step("mem4_n1",      1, 1, 0, 0, 0, 0, 0, 1, 0, 0, c_FRZ, c_RUN);
        step("mem4_release", 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, c_RUN, c_RUN);
        step("stop",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_RUN, c_RUN, 1'b1, 32'd2, 32'd0);
        step("idle_again",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_IDL, c_IDL);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage CPU; it drives the `PCWrite_i` input of the PC register and the write/flush/bubble controls of the IF/ID, ID/EX and later pipeline registers. It detects load-use hazards between ID and EX and applies branch/jump flushes. A small FSM with a down-counter freezes the whole pipeline while a multi-cycle data-memory access sits in MEM.

## Interface
- `MEM_LAT`, default 3: cycles a load/store occupies MEM. Legal values are 1 to 15.
- `CNT_W`, default 4: width of the wait counter. Must satisfy `2**CNT_W > MEM_LAT`.
- `clk_i` input, 1 bit: clock. All state updates on the rising edge.
- `rst_i` input, 1 bit: asynchronous, active-low reset.
- `start_i` input, 1 bit: CPU run enable.
- `IDEX_MemRead_i` input, 1 bit: the instruction in EX is a load.
- `IDEX_Rt_i` input, 5 bits: destination register of that load.
- `IFID_Rs_i` input, 5 bits: first source register of the instruction in ID.
- `IFID_Rt_i` input, 5 bits: second source register of the instruction in ID.
- `IFID_UsesRt_i` input, 1 bit: the ID instruction reads Rt.
- `EXMEM_MemAccess_i` input, 1 bit: a load/store is in MEM.
- `Branch_i` input, 1 bit: branch taken, resolved in ID.
- `Jump_i` input, 1 bit: jump in ID.
- `PCWrite_o` output, 1 bit: PC load enable.
- `IFIDWrite_o` output, 1 bit: IF/ID load enable.
- `IFIDFlush_o` output, 1 bit: clear IF/ID to a NOP on the next edge.
- `IDEXBubble_o` output, 1 bit: insert a NOP into ID/EX.
- `PipeStall_o` output, 1 bit: hold ID/EX, EX/MEM and MEM/WB.

## Operation
- States are IDLE, RUN and MEM_WAIT. Reset (`rst_i`=0) forces IDLE and clears the counter.
- IDLE:
  - Outputs: `PCWrite_o`=0, `IFIDWrite_o`=0, `IDEXBubble_o`=1, `PipeStall_o`=1, `IFIDFlush_o`=0.
  - Goes to RUN on the edge where `start_i`=1.
- In RUN and MEM_WAIT, `start_i`=0 returns the FSM to IDLE on the next edge. Outputs for that cycle still follow the current state.
- Memory freeze (highest priority, Mealy):
  - Applies in RUN when `EXMEM_MemAccess_i`=1 and `MEM_LAT`>1, and in MEM_WAIT when `cnt`!=0.
  - Outputs: `PCWrite_o`=0, `IFIDWrite_o`=0, `PipeStall_o`=1, `IDEXBubble_o`=0, `IFIDFlush_o`=0.
  - RUN entry loads `cnt`=`MEM_LAT`-2 and moves to MEM_WAIT.
  - MEM_WAIT with `cnt`!=0 decrements `cnt`.
  - MEM_WAIT with `cnt`==0 is the release cycle: no freeze, `EXMEM_MemAccess_i` is ignored, and the next state is RUN.
- Load-use hazard (second priority, combinational):
  - Condition: `IDEX_MemRead_i` && `IDEX_Rt_i`!=0 && (`IDEX_Rt_i`==`IFID_Rs_i` || (`IFID_UsesRt_i` && `IDEX_Rt_i`==`IFID_Rt_i`)).
  - Response: `PCWrite_o`=0, `IFIDWrite_o`=0, `IDEXBubble_o`=1, `IFIDFlush_o`=0.
- Control flush (third priority): `Branch_i`|`Jump_i` with no freeze and no load-use gives `IFIDFlush_o`=1 and `PCWrite_o`=1.
- Otherwise all enables are 1 and `IDEXBubble_o`, `IFIDFlush_o` and `PipeStall_o` are 0.
- Load-use and flush are evaluated in RUN and in the MEM_WAIT release cycle.

## Timing
- All outputs are combinational from state, counter and inputs. There are no registered outputs and no added latency.
- A load-use stall lasts exactly one cycle, because the load leaves EX on the next edge.
- A memory access first seen at cycle N freezes cycles N to N+`MEM_LAT`-2 and releases at N+`MEM_LAT`-1.
- With `MEM_LAT`=1 the FSM never leaves RUN for a memory access.
- A simultaneous load-use and branch gives the stall only. The branch re-evaluates on the next cycle.
- Back-to-back memory instructions: the second one is first seen in RUN after the release cycle and starts a new wait.
- Reset asserted mid-MEM_WAIT: immediate IDLE, counter cleared, IDLE outputs immediately.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - Adds output `stall_cycles_o` (32 bits).
  - It counts cycles with `PCWrite_o`=0 in RUN or MEM_WAIT, saturates at 0xFFFFFFFF and is cleared by reset.
- `HAZ_PERF_CNT_EN` undefined: the port and the counter are absent. Nothing else changes.

## Test plan
- Reset, then `start_i`=1 at cycle 2 → IDLE outputs through cycle 2; cycle 3 is RUN with `PCWrite_o`=1, `IFIDWrite_o`=1.
- Load-use with `IDEX_Rt_i`=5 and `IFID_Rs_i`=5 → one cycle of `PCWrite_o`=0, `IDEXBubble_o`=1. The same case with `IDEX_Rt_i`=0 → no stall.
- `MEM_LAT`=3, `EXMEM_MemAccess_i` held high from cycle N → `PipeStall_o`=1 at N and N+1, 0 at N+2. Repeat with `MEM_LAT`=1 → no freeze.
- Load-use and `Branch_i` in the same cycle → stall only, `IFIDFlush_o`=0. Branch alone next cycle → `IFIDFlush_o`=1, `PCWrite_o`=1.
- `rst_i` low at MEM_WAIT with `cnt`=1 → IDLE outputs immediately. After restart, a new access freezes the full `MEM_LAT`-1 cycles.
- With `HAZ_PERF_CNT_EN`: one load-use plus one `MEM_LAT`=3 access → `stall_cycles_o`=3.
